// File: rtl/mips_pkg.sv
// mips_pkg: shared encodings for the multicycle MIPS controller.
package mips_pkg;
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
    EXECUTE, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP
  } state_t;
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;
  localparam logic [1:0] AOP_ADD   = 2'b00;
  localparam logic [1:0] AOP_SUB   = 2'b01;
  localparam logic [1:0] AOP_FUNCT = 2'b10;
  localparam logic [1:0] SRCB_B    = 2'b00;
  localparam logic [1:0] SRCB_4    = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_IMM4 = 2'b11;
  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
endpackage

// File: rtl/mc_controller_aludec.sv
// aludec: maps aluop and funct to an ALU control code and flags supported functs.
module aludec
  import mips_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [5:0] funct,
  output logic [2:0] alucontrol,
  output logic       funct_ok
);
  logic [2:0] fctl;
  assign fctl = funct == F_ADD ? ALU_ADD :
                funct == F_SUB ? ALU_SUB :
                funct == F_AND ? ALU_AND :
                funct == F_OR  ? ALU_OR  :
                funct == F_SLT ? ALU_SLT : ALU_ADD;
  assign funct_ok = funct inside {F_ADD, F_SUB, F_AND, F_OR, F_SLT};
  assign alucontrol = aluop == AOP_SUB ? ALU_SUB : aluop == AOP_FUNCT ? fctl : ALU_ADD;
endmodule

// File: rtl/mc_controller.sv
// mc_controller: multicycle MIPS main FSM with memory-ready stalls and sticky illegal flag.
module mc_controller
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       memready,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic       pcen,
  output logic       illegal
);
  state_t     state, state_d;
  logic [1:0] aluop;
  logic       pcwrite, branch, mw, irw, rw, funct_ok, op_ok;
  aludec u_aludec (.aluop(aluop), .funct(funct), .alucontrol(alucontrol), .funct_ok(funct_ok));
  assign op_ok = op == OP_R ? funct_ok : op inside {OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J};
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state   <= FETCH;
      illegal <= 1'b0;
    end else begin
      state <= state_d;
      if (state == DECODE && !op_ok) illegal <= 1'b1;
    end
  always_comb begin
    state_d  = state;
    iord     = 1'b0;
    mw       = 1'b0;
    irw      = 1'b0;
    regdst   = 1'b0;
    memtoreg = 1'b0;
    rw       = 1'b0;
    alusrca  = 1'b0;
    alusrcb  = SRCB_B;
    pcsrc    = PC_ALU;
    aluop    = AOP_ADD;
    pcwrite  = 1'b0;
    branch   = 1'b0;
    case (state)
      FETCH: begin
        alusrcb = SRCB_4;
        irw     = memready;
        pcwrite = memready;
        state_d = memready ? DECODE : FETCH;
      end
      DECODE: begin
        alusrcb = SRCB_IMM4;
        state_d = !op_ok                        ? FETCH   :
                  op == OP_LW || op == OP_SW    ? MEMADR  :
                  op == OP_R                    ? EXECUTE :
                  op == OP_BEQ                  ? BRANCH  :
                  op == OP_ADDI                 ? ADDIEX  : JUMP;
      end
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
        state_d = op == OP_SW ? MEMWR : MEMRD;
      end
      MEMRD: begin
        iord    = 1'b1;
        state_d = memready ? MEMWB : MEMRD;
      end
      MEMWB: begin
        memtoreg = 1'b1;
        rw       = 1'b1;
        state_d  = FETCH;
      end
      MEMWR: begin
        iord    = 1'b1;
        mw      = 1'b1;
        state_d = memready ? FETCH : MEMWR;
      end
      EXECUTE: begin
        alusrca = 1'b1;
        aluop   = AOP_FUNCT;
        state_d = ALUWB;
      end
      ALUWB: begin
        regdst  = 1'b1;
        rw      = 1'b1;
        state_d = FETCH;
      end
      BRANCH: begin
        alusrca = 1'b1;
        aluop   = AOP_SUB;
        pcsrc   = PC_ALUOUT;
        branch  = 1'b1;
        state_d = FETCH;
      end
      ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
        state_d = ADDIWB;
      end
      ADDIWB: begin
        rw      = 1'b1;
        state_d = FETCH;
      end
      JUMP: begin
        pcsrc   = PC_JUMP;
        pcwrite = 1'b1;
        state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end
  // Strobes are masked while reset is held so a waiting access cannot complete.
  assign memwrite = reset & mw;
  assign irwrite  = reset & irw;
  assign regwrite = reset & rw;
  assign pcen     = reset & (pcwrite | (branch & zero));
endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller: randomized instruction stream checked against a per-instruction cycle model.
module tb_mc_controller;
  logic       clk = 1'b0, reset = 1'b1, zero = 1'b0, memready = 1'b1;
  logic [5:0] op = '0, funct = '0;
  logic       iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, pcen, illegal;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  int         n_tests = 0, n_fail = 0;
  logic       ill_m = 1'b0;
  mc_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .memready(memready),
    .iord(iord), .memwrite(memwrite), .irwrite(irwrite), .regdst(regdst),
    .memtoreg(memtoreg), .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb),
    .pcsrc(pcsrc), .alucontrol(alucontrol), .pcen(pcen), .illegal(illegal)
  );
  always #5 clk = ~clk;
  wire [15:0] obs = {illegal, iord, memwrite, irwrite, regdst, memtoreg, regwrite,
                     alusrca, alusrcb, pcsrc, alucontrol, pcen};
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [14:0] mk(input logic io, mwr, ir, rd, mtr, rw, sa,
                                     input logic [1:0] sb, pc, input logic [2:0] alu,
                                     input logic pe);
    return {io, mwr, ir, rd, mtr, rw, sa, sb, pc, alu, pe};
  endfunction
  function automatic logic [14:0] v_fetch(input logic mr);
    return mk(0, 0, mr, 0, 0, 0, 0, 2'b01, 2'b00, 3'b010, mr);
  endfunction
  function automatic logic [14:0] v_dec();    return mk(0,0,0,0,0,0,0,2'b11,2'b00,3'b010,0); endfunction
  function automatic logic [14:0] v_adr();    return mk(0,0,0,0,0,0,1,2'b10,2'b00,3'b010,0); endfunction
  function automatic logic [14:0] v_memrd();  return mk(1,0,0,0,0,0,0,2'b00,2'b00,3'b010,0); endfunction
  function automatic logic [14:0] v_memwb();  return mk(0,0,0,0,1,1,0,2'b00,2'b00,3'b010,0); endfunction
  function automatic logic [14:0] v_memwr();  return mk(1,1,0,0,0,0,0,2'b00,2'b00,3'b010,0); endfunction
  function automatic logic [14:0] v_aluwb();  return mk(0,0,0,1,0,1,0,2'b00,2'b00,3'b010,0); endfunction
  function automatic logic [14:0] v_addiwb(); return mk(0,0,0,0,0,1,0,2'b00,2'b00,3'b010,0); endfunction
  function automatic logic [14:0] v_jump();   return mk(0,0,0,0,0,0,0,2'b00,2'b10,3'b010,1); endfunction
  function automatic logic [14:0] v_branch(input logic z);
    return mk(0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 3'b110, z);
  endfunction
  function automatic logic [2:0] alu_of(input logic [5:0] f);
    case (f)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      default:   return 3'b111;
    endcase
  endfunction
  function automatic logic f_ok(input logic [5:0] f);
    return f inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
  endfunction
  task automatic step(input logic mr, input logic [14:0] exp, input string tag);
    memready = mr;
    @(negedge clk);
    check(tag, obs, {ill_m, exp});
    @(posedge clk);
    #1;
  endtask
  task automatic do_instr(input logic [5:0] o, f, input logic z, input int nf, nm);
    op = o;
    funct = f;
    zero = z;
    repeat (nf) step(1'b0, v_fetch(1'b0), "fetch_wait");
    step(1'b1, v_fetch(1'b1), "fetch");
    step(1'($urandom), v_dec(), "decode");
    case (o)
      6'b100011: begin
        step(1'($urandom), v_adr(), "lw_memadr");
        repeat (nm) step(1'b0, v_memrd(), "memrd_wait");
        step(1'b1, v_memrd(), "memrd");
        step(1'($urandom), v_memwb(), "memwb");
      end
      6'b101011: begin
        step(1'($urandom), v_adr(), "sw_memadr");
        repeat (nm) step(1'b0, v_memwr(), "memwr_wait");
        step(1'b1, v_memwr(), "memwr");
      end
      6'b000000: begin
        if (f_ok(f)) begin
          step(1'($urandom), mk(0,0,0,0,0,0,1,2'b00,2'b00,alu_of(f),0), "execute");
          step(1'($urandom), v_aluwb(), "aluwb");
        end else ill_m = 1'b1;
      end
      6'b000100: step(1'($urandom), v_branch(z), "branch");
      6'b001000: begin
        step(1'($urandom), v_adr(), "addiex");
        step(1'($urandom), v_addiwb(), "addiwb");
      end
      6'b000010: step(1'($urandom), v_jump(), "jump");
      default: ill_m = 1'b1;
    endcase
  endtask
  task automatic reset_pulse();
    memready = 1'b1;
    reset = 1'b0;
    ill_m = 1'b0;
    #1;
    check("rst_strobes", {12'd0, memwrite, irwrite, regwrite, pcen}, 16'd0);
    @(negedge clk);
    check("rst_state", obs, {1'b0, v_fetch(1'b0)});
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask
  localparam logic [5:0] OPS [6] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};
  localparam logic [5:0] FNS [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
  initial begin
    #1 reset = 1'b0;
    #1;
    check("rst_strobes0", {12'd0, memwrite, irwrite, regwrite, pcen}, 16'd0);
    @(negedge clk);
    check("rst_state0", obs, {1'b0, v_fetch(1'b0)});
    @(posedge clk);
    #1 reset = 1'b1;
    do_instr(6'b100011, 6'd0, 1'b0, 0, 0);
    do_instr(6'b101011, 6'd0, 1'b0, 0, 3);
    do_instr(6'b000100, 6'd0, 1'b1, 0, 0);
    do_instr(6'b000100, 6'd0, 1'b0, 0, 0);
    do_instr(6'b000000, 6'b101010, 1'b0, 0, 0);
    do_instr(6'b000000, 6'b000000, 1'b0, 0, 0);
    reset_pulse();
    do_instr(6'b111111, 6'd0, 1'b0, 0, 0);
    do_instr(6'b001000, 6'd0, 1'b0, 1, 0);
    do_instr(6'b000010, 6'd0, 1'b1, 0, 0);
    check("illegal_sticky", {15'd0, illegal}, 16'd1);
    reset_pulse();
    // Abort a store while it is stalled in its write wait.
    op = 6'b101011;
    step(1'b1, v_fetch(1'b1), "ab_fetch");
    step(1'b1, v_dec(), "ab_decode");
    step(1'b1, v_adr(), "ab_memadr");
    step(1'b0, v_memwr(), "ab_memwr_wait");
    memready = 1'b0;
    #2;
    reset_pulse();
    do_instr(6'b000010, 6'd0, 1'b0, 0, 0);
    for (int i = 0; i < 200; i++) begin
      int k;
      logic [5:0] o, f;
      k = $urandom_range(0, 11);
      o = OPS[$urandom_range(0, 5)];
      f = FNS[$urandom_range(0, 4)];
      if (k == 9) o = 6'($urandom);
      if (k == 10) f = 6'($urandom);
      if (k == 11) reset_pulse();
      else do_instr(o, f, 1'($urandom), $urandom_range(0, 2), $urandom_range(0, 3));
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mc_controller.md
MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 Parameters: none.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 op  input  6  instr[31:26] from instruction register.
REQ-005 funct  input  6  instr[5:0] from instruction register.
REQ-006 zero  input  1  ALU zero flag from datapath.
REQ-007 memready  input  1  unified memory completes the current access this cycle.
REQ-008 iord  output  1  memory address select: 0=PC, 1=ALUOut.
REQ-009 memwrite  output  1  memory write strobe.
REQ-010 irwrite  output  1  instruction register load enable.
REQ-011 regdst  output  1  write-register select: 0=rt, 1=rd.
REQ-012 memtoreg  output  1  writeback select: 0=ALUOut, 1=Data register.
REQ-013 regwrite  output  1  register file write enable.
REQ-014 alusrca  output  1  SrcA select: 0=PC, 1=register A.
REQ-015 alusrcb  output  2  SrcB select: 00=B, 01=constant 4, 10=SignImm, 11=SignImm<<2.
REQ-016 pcsrc  output  2  next-PC select: 00=ALUResult, 01=ALUOut, 10=jump target.
REQ-017 alucontrol  output  3  010 add, 110 sub, 000 and, 001 or, 111 slt.
REQ-018 pcen  output  1  PC register enable.
REQ-019 illegal  output  1  sticky flag: unsupported instruction decoded.

Function
REQ-020 Supported ops: R-type 000000 (funct add 100000, sub 100010, and 100100, or 100101, slt 101010), lw 100011, sw 101011, beq 000100, addi 001000, j 000010.
REQ-021 States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTE, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP.
REQ-022 FETCH: iord=0, alusrca=0, alusrcb=01, aluop add, pcsrc=00; irwrite and pcwrite = memready; holds while memready=0; goes to DECODE when memready=1.
REQ-023 DECODE: alusrca=0, alusrcb=11, add; next state lw/sw->MEMADR, R->EXECUTE, beq->BRANCH, addi->ADDIEX, j->JUMP.
REQ-024 DECODE with unsupported op, or R-type with unsupported funct: next state FETCH, illegal set to 1 on that edge, no register/memory write issued.
REQ-025 MEMADR: alusrca=1, alusrcb=10, add; lw->MEMRD, sw->MEMWR.
REQ-026 MEMRD: iord=1; holds while memready=0; ->MEMWB when memready=1.
REQ-027 MEMWB: regdst=0, memtoreg=1, regwrite=1; ->FETCH.
REQ-028 MEMWR: iord=1, memwrite=1 every cycle in state; holds while memready=0; ->FETCH when memready=1.
REQ-029 EXECUTE: alusrca=1, alusrcb=00, alucontrol from funct; ->ALUWB.
REQ-030 ALUWB: regdst=1, memtoreg=0, regwrite=1; ->FETCH.
REQ-031 BRANCH: alusrca=1, alusrcb=00, sub, pcsrc=01, branch=1; ->FETCH.
REQ-032 ADDIEX: alusrca=1, alusrcb=10, add; ->ADDIWB.
REQ-033 ADDIWB: regdst=0, memtoreg=0, regwrite=1; ->FETCH.
REQ-034 JUMP: pcsrc=10, pcwrite=1; ->FETCH.
REQ-035 pcen = pcwrite OR (branch AND zero), combinational.
REQ-036 Outputs not listed for a state are 0; alucontrol defaults to 010.
REQ-037 Cycle counts at memready=1: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2; each memready=0 cycle in FETCH/MEMRD/MEMWR adds exactly one cycle.

Reset
REQ-038 While reset=0: state=FETCH, illegal=0, and memwrite, irwrite, regwrite, pcen forced 0 regardless of memready.
REQ-039 Reset asserted in any state, including mid-MEMWR wait, aborts the instruction; first cycle after release is FETCH.

Structure
REQ-040 Shared package mips_pkg holds: state enum, opcode and funct constants, alucontrol codes, alusrcb/pcsrc encodings.
REQ-041 One sub-module: aludec (combinational), mapping aluop (2 bits: 00 add, 01 sub, 10 funct) plus funct to alucontrol and a funct-valid flag.
REQ-042 Main FSM: one state register, one combinational next-state/output block.

Verification
REQ-043 lw (op 100011), memready=1 throughout -> FETCH,DECODE,MEMADR,MEMRD,MEMWB; regwrite=1, memtoreg=1 only in cycle 5; pcen=1 only in cycle 1.
REQ-044 sw with memready=0 for 3 cycles in MEMWR -> memwrite=1 for 4 consecutive cycles, then FETCH; total 7 cycles.
REQ-045 beq, zero=1 -> pcen=1 in cycle 3 with pcsrc=01, alucontrol=110; repeat with zero=0 -> pcen=0 in cycle 3.
REQ-046 R-type funct 101010 -> alucontrol=111 in EXECUTE, regwrite=1, regdst=1 in ALUWB; funct 000000 -> illegal=1 after DECODE, next state FETCH, no regwrite.
REQ-047 op 111111 -> illegal=1 and stays 1 across following legal addi; reset pulse -> illegal=0.
REQ-048 reset=0 during MEMWR wait (memready=0) -> memwrite drops immediately; after release, FETCH with iord=0.
